// File: rtl/ahb_arbiter_slave_1.sv
// ahb_arbiter_slave_1
// Round-robin, burst-aware arbiter that owns the one-hot select of the slave_1
// master-to-slave payload mux. A granted master keeps slave_1 for a whole
// fixed-length burst, for an INCR burst until it drops its request, or for as
// long as it holds HMASTLOCK.
//
// Ports:
//   HCLK       system clock
//   HRESETn    asynchronous active-low reset
//   req        per-master request for slave_1 (decoded HSEL)
//   lock       per-master HMASTLOCK
//   htrans     per-master HTRANS, master m in bits [2m+1:2m]
//   hburst     per-master HBURST, master m in bits [3m+2:3m]
//   hready     slave_1 HREADYOUT; every non-reset update waits for it
//   sel_addr   one-hot address-phase select (all-zero = no owner)
//   sel_data   one-hot data-phase select (sel_addr delayed by one accepted beat)
//   master_id  index of the sel_addr owner, 0 when there is none
module ahb_arbiter_slave_1 #(
  parameter int CHANNEL_NUM = 3,
  parameter int ID_W        = $clog2(CHANNEL_NUM)
) (
  input  logic                     HCLK,
  input  logic                     HRESETn,
  input  logic [CHANNEL_NUM-1:0]   req,
  input  logic [CHANNEL_NUM-1:0]   lock,
  input  logic [2*CHANNEL_NUM-1:0] htrans,
  input  logic [3*CHANNEL_NUM-1:0] hburst,
  input  logic                     hready,
  output logic [CHANNEL_NUM-1:0]   sel_addr,
  output logic [CHANNEL_NUM-1:0]   sel_data,
  output logic [ID_W-1:0]          master_id
);

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ    = 2'b11;
  localparam logic [2:0] BU_SINGLE = 3'b000;
  localparam logic [2:0] BU_INCR   = 3'b001;

  typedef enum logic {ST_IDLE, ST_OWNED} state_t;

  state_t          state_reg;
  logic [ID_W-1:0] ptr_reg;   // last granted master; it gets lowest priority next
  logic [3:0]      cnt_reg;   // remaining SEQ beats of the current fixed burst

  // Per-master views of the packed transfer-control buses.
  logic [1:0] trans_arr [CHANNEL_NUM];
  logic [2:0] burst_arr [CHANNEL_NUM];

  genvar gi;
  generate
    for (gi = 0; gi < CHANNEL_NUM; gi++) begin : g_unpack
      assign trans_arr[gi] = htrans[2*gi +: 2];
      assign burst_arr[gi] = hburst[3*gi +: 3];
    end
  endgenerate

  // Beats still to come after the NONSEQ of a burst. SINGLE and INCR load 0;
  // INCR never relies on the counter.
  function automatic logic [3:0] burst_len_m1(input logic [2:0] b);
    case (b[2:1])
      2'b01:   return 4'd3;
      2'b10:   return 4'd7;
      2'b11:   return 4'd15;
      default: return 4'd0;
    endcase
  endfunction

  // Owner-side decode.
  logic [1:0] owner_trans;
  logic [2:0] owner_burst;
  logic       owner_req;
  logic       owner_lock;
  logic       beat_nonseq;
  logic       beat_seq;
  logic       last_beat;
  logic       rearb;

  assign owner_trans = trans_arr[master_id];
  assign owner_burst = burst_arr[master_id];
  assign owner_req   = req[master_id];
  assign owner_lock  = lock[master_id];
  assign beat_nonseq = (owner_trans == TR_NONSEQ);
  assign beat_seq    = (owner_trans == TR_SEQ);

  assign last_beat = (beat_nonseq && owner_burst == BU_SINGLE) ||
                     (beat_seq && owner_burst != BU_INCR && cnt_reg == 4'd1);

  // Only meaningful in ST_OWNED with hready=1; a held lock overrides every
  // release condition, including the natural end of a burst.
  assign rearb = !owner_lock &&
                 (last_beat || owner_trans == TR_IDLE ||
                  (owner_burst == BU_INCR && !owner_req));

  // Round-robin pick: scan from ptr_reg+1 upward, wrapping, so the previous
  // owner is considered last.
  logic            win_found;
  logic [ID_W-1:0] win_id;
  logic [ID_W-1:0] cand;

  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    cand      = '0;
    for (int k = 1; k <= CHANNEL_NUM; k++) begin
      cand = ID_W'((int'(ptr_reg) + k) % CHANNEL_NUM);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_id    = cand;
      end
    end
  end

  logic [CHANNEL_NUM-1:0] win_onehot;
  assign win_onehot = {{(CHANNEL_NUM-1){1'b0}}, 1'b1} << win_id;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_reg <= ST_IDLE;
      ptr_reg   <= ID_W'(CHANNEL_NUM - 1);
      cnt_reg   <= '0;
      sel_addr  <= '0;
      sel_data  <= '0;
      master_id <= '0;
    end else if (hready) begin
      sel_data <= sel_addr;
      case (state_reg)
        ST_IDLE: begin
          if (win_found) begin
            sel_addr  <= win_onehot;
            master_id <= win_id;
            ptr_reg   <= win_id;
            state_reg <= ST_OWNED;
          end
        end
        ST_OWNED: begin
          if (beat_nonseq) begin
            cnt_reg <= burst_len_m1(owner_burst);
          end else if (beat_seq && cnt_reg != 4'd0) begin
            cnt_reg <= cnt_reg - 4'd1;
          end
          if (rearb) begin
            if (win_found) begin
              sel_addr  <= win_onehot;
              master_id <= win_id;
              ptr_reg   <= win_id;
            end else begin
              sel_addr  <= '0;
              master_id <= '0;
              state_reg <= ST_IDLE;
            end
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  a_onehot_sel : assert property (@(posedge HCLK) disable iff (!HRESETn)
    $onehot0(sel_addr) && $onehot0(sel_data));

endmodule
